prog_loader: RTL and testbench

Byte-stream program loader for the picoMIPS core: accepts a framed instruction image over a valid/ready byte interface and writes it word by word into the writable program memory. Holds the processor in reset from power-up until a load completes, then releases it.

---
 rtl/prog_loader.sv | 164 ++++++++++++++++
 tb/tb_prog_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader for picoMIPS: writes a framed image into program memory, holding the CPU in reset until done.
// Defining LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to the frame (CHECK state).
module prog_loader #(
    parameter int Psize = 4,
    parameter int Isize = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             we,
    output logic [Psize-1:0] waddr,
    output logic [Isize-1:0] wdata,
    output logic             cpu_reset,
    output logic             done,
    output logic             error,
    output logic [2:0]       dbg_state
);
    localparam int NB = (Isize + 7) / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [Psize:0] ONE_W = 1;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, LAST, DONE, ERROR} state_t;
`else
    typedef enum logic [2:0] {IDLE, COUNT, DATA, LAST, DONE, ERROR} state_t;
`endif

    // Handshake: a byte moves on a rising edge where rx_valid && rx_ready.
    // rx_ready depends only on the registered state, never on rx_valid.
    state_t            state_q;
    logic [Psize:0]    cnt_q;
    logic [Psize:0]    widx_q;
    logic [BW-1:0]     bidx_q;
    logic [NB*8-1:0]   shift_q;
    logic              we_q;
    logic [Psize-1:0]  waddr_q;
    logic [Isize-1:0]  wdata_q;
    logic              cpu_reset_q;
    logic              done_q;
    logic              error_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xor_q;
`endif

    logic              accept;
    logic              last_byte;
    logic              last_word;
    logic [NB*8-1:0]   word_d;

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            COUNT, DATA: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHECK:       rx_ready = 1'b1;
`endif
            default:     rx_ready = 1'b0;
        endcase
    end

    assign accept    = rx_valid && rx_ready;
    assign last_byte = (bidx_q == BW'(NB - 1));
    assign last_word = (widx_q == cnt_q - ONE_W);
    // Bytes arrive MSB first; older bytes fall off the top of the window.
    assign word_d    = (shift_q << 8) | (NB*8)'(rx_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            widx_q      <= '0;
            bidx_q      <= '0;
            shift_q     <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: if (start) state_q <= COUNT;
                COUNT: if (accept) begin
                    if (rx_data == 8'd0 || int'(rx_data) > (1 << Psize)) begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                    end else begin
                        cnt_q   <= (Psize+1)'(rx_data);
                        widx_q  <= '0;
                        bidx_q  <= '0;
                        state_q <= DATA;
                    end
`ifdef LOADER_CHECKSUM_EN
                    xor_q <= rx_data;
`endif
                end
                DATA: if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    xor_q <= xor_q ^ rx_data;
`endif
                    if (last_byte) begin
                        we_q    <= 1'b1;
                        waddr_q <= widx_q[Psize-1:0];
                        wdata_q <= word_d[Isize-1:0];
                        bidx_q  <= '0;
                        widx_q  <= widx_q + ONE_W;
                        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= CHECK;
`else
                            state_q <= LAST;
`endif
                        end
                    end else begin
                        shift_q <= word_d;
                        bidx_q  <= bidx_q + BW'(1);
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: if (accept) begin
                    if (rx_data == xor_q) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                    end
                end
`endif
                LAST: begin
                    state_q     <= DONE;
                    done_q      <= 1'b1;
                    cpu_reset_q <= 1'b0;
                end
                DONE: if (start) begin
                    state_q     <= COUNT;
                    done_q      <= 1'b0;
                    cpu_reset_q <= 1'b1;
                end
                ERROR: if (start) begin
                    state_q <= COUNT;
                    error_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames, write scoreboard fed by a frame-level model, latency checks on done/error.
// Define LOADER_CHECKSUM_EN for both files to exercise the checksum build.
module tb_prog_loader;
    localparam int PSIZE = 4;
    localparam int ISIZE = 17;
    localparam int NB    = (ISIZE + 7) / 8;
    localparam int EW    = PSIZE + ISIZE;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic             we;
    logic [PSIZE-1:0] waddr;
    logic [ISIZE-1:0] wdata;
    logic             cpu_reset;
    logic             done;
    logic             error;
    logic [2:0]       dbg_state;

    int n_checks = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];
    logic [7:0]    frame_q[$];
    logic [EW-1:0] cmp_e;
`ifdef LOADER_CHECKSUM_EN
    bit corrupt_csum = 1'b0;
`endif

    prog_loader #(.Psize(PSIZE), .Isize(ISIZE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: word w is the NB data bytes read as a big-endian number, kept mod 2^ISIZE.
    function automatic bit count_ok(input logic [7:0] n);
        return (n >= 8'd1) && (int'(n) <= (1 << PSIZE));
    endfunction

    function automatic logic [ISIZE-1:0] model_word(input int w);
        longint word = 0;
        for (int b = 0; b < NB; b++) word = word * 256 + longint'(frame_q[1 + w*NB + b]);
        return ISIZE'(word % (64'd1 << ISIZE));
    endfunction

`ifdef LOADER_CHECKSUM_EN
    function automatic logic [7:0] frame_xor();
        logic [7:0] cs = 8'h00;
        foreach (frame_q[i]) cs = cs ^ frame_q[i];
        return cs;
    endfunction
`endif

    task automatic build_expect();
        int n = int'(frame_q[0]);
        if (count_ok(frame_q[0]))
            for (int w = 0; w < n; w++) exp_q.push_back({PSIZE'(w), model_word(w)});
    endtask

    // Scoreboard: every write strobe must match the next expected write
    always @(negedge clk) begin
        if (!reset) begin
            if (we) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_we: waddr 0x%0h wdata 0x%0h, none expected at %0t", waddr, wdata, $time);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("waddr", 32'(waddr), 32'(cmp_e[EW-1:ISIZE]));
                    check("wdata", 32'(wdata), 32'(cmp_e[ISIZE-1:0]));
                end
            end
            check("cpu_reset_vs_done", 32'(cpu_reset), 32'(!done));
            check("done_and_error", 32'(done & error), 32'd0);
        end
    end

    // Driver tasks
    task automatic new_frame(input logic [7:0] n);
        frame_q.delete();
        frame_q.push_back(n);
    endtask

    task automatic push3(input logic [23:0] w);
        frame_q.push_back(w[23:16]);
        frame_q.push_back(w[15:8]);
        frame_q.push_back(w[7:0]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        check("byte_accepted", 32'(ok), 32'd1);
    endtask

    task automatic start_load();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("ready_after_start", 32'(rx_ready), 32'd1);
        check("done_cleared", 32'(done), 32'd0);
        check("error_cleared", 32'(error), 32'd0);
        check("cpu_held_on_start", 32'(cpu_reset), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_waddr"}, 32'(waddr), 32'd0);
        check({tag, "_wdata"}, 32'(wdata), 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic run_frame(input bit gap);
        bit cnt_ok;
        bit ok;
        int nbytes;
        cnt_ok = count_ok(frame_q[0]);
        ok = cnt_ok;
        build_expect();
`ifdef LOADER_CHECKSUM_EN
        if (cnt_ok) begin
            frame_q.push_back(corrupt_csum ? 8'h00 : frame_xor());
            ok = !corrupt_csum;
        end
`endif
        nbytes = cnt_ok ? frame_q.size() : 1;
        for (int i = 0; i < nbytes; i++) begin
            if (gap && i > 0) begin
                rx_valid = 1'b0;
                rx_data  = 8'h5A;
                @(posedge clk);
                #1;
            end
            send_byte(frame_q[i]);
        end
        rx_valid = 1'b0;
        if (!cnt_ok) begin
            @(negedge clk);
            check("bad_count_error", 32'(error), 32'd1);
            check("bad_count_cpu_reset", 32'(cpu_reset), 32'd1);
            check("bad_count_done", 32'(done), 32'd0);
            check("bad_count_ready", 32'(rx_ready), 32'd0);
        end else begin
`ifndef LOADER_CHECKSUM_EN
            @(negedge clk);
            check("done_not_yet", 32'(done), 32'd0);
            check("we_on_last_word", 32'(we), 32'd1);
`endif
            @(negedge clk);
            check("frame_done", 32'(done), 32'(ok));
            check("frame_error", 32'(error), 32'(!ok));
            check("frame_cpu_reset", 32'(cpu_reset), 32'(!ok));
            check("frame_ready_low", 32'(rx_ready), 32'd0);
        end
        check("writes_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("idle");
        @(posedge clk);
        #1;

        // Two words, rx_valid held high
        start_load();
        new_frame(8'd2);
        push3(24'h012345);
        push3(24'h00ABCD);
        check("model_w0", 32'(model_word(0)), 32'h12345);
        check("model_w1", 32'(model_word(1)), 32'h0ABCD);
        run_frame(1'b0);

        // Same frame, rx_valid toggling; restart from DONE
        start_load();
        new_frame(8'd2);
        push3(24'h012345);
        push3(24'h00ABCD);
        run_frame(1'b1);

        // Rejected counts
        start_load();
        new_frame(8'h00);
        run_frame(1'b0);
        start_load();
        new_frame(8'h11);
        run_frame(1'b0);

        // Recovery from ERROR; pad bits above ISIZE dropped
        start_load();
        new_frame(8'd3);
        push3(24'hFFFFFF);
        push3(24'h1ABCDE);
        push3(24'h020001);
        check("model_pad0", 32'(model_word(0)), 32'h1FFFF);
        check("model_pad1", 32'(model_word(1)), 32'h0BCDE);
        check("model_pad2", 32'(model_word(2)), 32'h00001);
        run_frame(1'b0);

        // Full memory depth
        start_load();
        new_frame(8'd16);
        for (int i = 0; i < 16*NB; i++) frame_q.push_back(8'((i * 37 + 5) & 255));
        run_frame(1'b0);

        // Reset in the middle of word 1
        start_load();
        new_frame(8'd2);
        push3(24'h012345);
        push3(24'h00ABCD);
        build_expect();
        for (int i = 0; i < 5; i++) send_byte(frame_q[i]);
        rx_valid = 1'b0;
        reset = 1'b1;
        #2;
        check_reset_vals("mid_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("after_reset");
        @(posedge clk);
        #1;
        start_load();
        new_frame(8'd1);
        push3(24'h000007);
        run_frame(1'b0);

`ifdef LOADER_CHECKSUM_EN
        start_load();
        new_frame(8'd1);
        push3(24'h001234);
        check("model_xor", 32'(frame_xor()), 32'h27);
        check("model_cs_word", 32'(model_word(0)), 32'h01234);
        corrupt_csum = 1'b0;
        run_frame(1'b0);
        start_load();
        new_frame(8'd1);
        push3(24'h001234);
        corrupt_csum = 1'b1;
        run_frame(1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
